// File: rtl/fsm_arb.sv
// Round-robin arbiter for CH requesters driving a single ack-paced target port.
// Runs multi-beat read/write bursts with an ack-timeout watchdog.
module fsm_arb #(
  parameter int unsigned CH      = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH-1:0]         req,
  input  logic [CH-1:0]         we,
  input  logic [CH*LEN_W-1:0]   len,
  input  logic                  ack,
  output logic                  idle,
  output logic                  read,
  output logic                  write,
  output logic [CH-1:0]         grant,
  output logic [LEN_W-1:0]      beat_cnt,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IW = $clog2(CH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [TW-1:0]     tmo_q;

  logic [LEN_W-1:0]  len_a [CH];
  logic              found;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     idx_b;
  logic              busy;
  logic              last_beat;

  for (genvar g = 0; g < CH; g++) begin : g_len
    assign len_a[g] = len[g*LEN_W +: LEN_W];
  end

  // First requester after the last owner, wrapping; the owner is also the new pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_b = '0;
    for (int unsigned k = 1; k <= CH; k++) begin
      idx_b = IW'((32'(ptr_q) + k) % CH);
      if (!found && req[idx_b]) begin
        found = 1'b1;
        pick  = idx_b;
      end
    end
  end

  assign busy      = (state_q == S_READ) || (state_q == S_WRITE);
  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(CH - 1);
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            ptr_q   <= pick;
            len_q   <= len_a[pick];
            beat_q  <= '0;
            tmo_q   <= '0;
            state_q <= we[pick] ? S_WRITE : S_READ;
          end
        end
        S_READ, S_WRITE: begin
          if (ack) begin
            tmo_q <= '0;
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              beat_q <= beat_q + LEN_W'(1);
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_q + TW'(1) == TW'(TIMEOUT)) begin
              beat_q  <= '0;
              state_q <= S_ERROR;
            end
          end
        end
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idle     = (state_q == S_IDLE);
  assign read     = (state_q == S_READ);
  assign write    = (state_q == S_WRITE);
  assign error    = (state_q == S_ERROR);
  assign grant    = busy ? (CH'(1) << ptr_q) : '0;
  assign beat_cnt = beat_q;
  assign done     = busy && ack && last_beat;

endmodule

// File: tb/tb_fsm_arb.sv
// Bench for fsm_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_fsm_arb;

  localparam int CH      = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [CH-1:0]       req;
  logic [CH-1:0]       we;
  logic [CH*LEN_W-1:0] len;
  logic                ack;
  logic                idle, read, write, done, error;
  logic [CH-1:0]       grant;
  logic [LEN_W-1:0]    beat_cnt;

  fsm_arb #(.CH(CH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .len(len), .ack(ack),
    .idle(idle), .read(read), .write(write), .grant(grant),
    .beat_cnt(beat_cnt), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 read burst, 2 write burst, 3 error cycle.
  int               m_mode, m_ptr, m_ch, m_beats, m_miss;
  logic [LEN_W-1:0] m_len;
  int               gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = CH - 1; m_ch = 0; m_beats = 0; m_miss = 0; m_len = '0;
  endtask

  function automatic logic [12:0] model_out(input logic a);
    logic b;
    b = (m_mode == 1) || (m_mode == 2);
    return {m_mode == 0, m_mode == 1, m_mode == 2, m_mode == 3,
            b ? 4'(1 << m_ch) : 4'b0000, 4'(m_beats),
            b && a && (32'(m_len) == 32'(m_beats))};
  endfunction

  task automatic model_step();
    int  c;
    bit  got;
    case (m_mode)
      0: begin
        got = 0;
        for (int j = 1; j <= CH; j++) begin
          c = (m_ptr + j) % CH;
          if (!got && req[c]) begin got = 1; m_ch = c; end
        end
        if (got) begin
          m_ptr = m_ch; m_len = len[m_ch*LEN_W +: LEN_W];
          m_mode = we[m_ch] ? 2 : 1; m_beats = 0; m_miss = 0;
          gq.push_back(m_ch);
        end
      end
      1, 2: begin
        if (ack) begin
          m_miss = 0;
          if (32'(m_len) == 32'(m_beats)) begin m_mode = 0; m_beats = 0; end
          else m_beats++;
        end else begin
          m_miss++;
          if (m_miss == TIMEOUT) begin m_mode = 3; m_beats = 0; end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  // One clock: inputs already driven after a negedge; check, advance, realign.
  task automatic cyc(input logic a);
    ack = a;
    #1;
    check("cycle_outputs", 32'({idle, read, write, error, grant, beat_cnt, done}), 32'(model_out(a)));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  int wc, rc, ec;

  initial begin
    reset = 1'b1; req = '0; we = '0; len = '0; ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_values", 32'({idle, read, write, error, grant, beat_cnt, done}), 32'(13'b1_0_0_0_0000_0000_0));
    reset = 1'b0;
    cyc(0);

    // Single write burst on ch2, len=3.
    req = 4'b0100; we = 4'b0100; len = '0; len[2*LEN_W +: LEN_W] = 4'd3;
    cyc(1);
    req = '0; we = '0; len = '0;
    wc = 0;
    for (int k = 0; k < 6; k++) begin
      if (write === 1'b1 && grant === 4'b0100) wc++;
      cyc(1);
    end
    check("write_burst_cycles", 32'(wc), 32'd4);
    check("write_burst_owner", 32'(gq[$]), 32'd2);

    // Reset in the middle of a read burst at beat_cnt=2.
    req = 4'b0010; we = '0; len = '0; len[1*LEN_W +: LEN_W] = 4'd5;
    cyc(1);
    req = '0;
    cyc(1); cyc(1);
    check("pre_reset_beat", 32'(beat_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'({idle, read, write, error, grant, beat_cnt, done}), 32'(13'b1_0_0_0_0000_0000_0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111; len = '0;
    cyc(1);
    check("post_reset_first_grant", 32'(gq[$]), 32'd0);
    req = '0;
    cyc(1); cyc(0);

    // Round-robin from a fresh reset.
    reset = 1'b1; #1; model_reset();
    @(negedge clk);
    reset = 1'b0;
    gq.delete();
    req = 4'b1011; we = '0; len = '0;
    for (int k = 0; k < 8; k++) cyc(1);
    req = '0;
    cyc(0);
    check("rr_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      check("rr_0", 32'(gq[0]), 32'd0);
      check("rr_1", 32'(gq[1]), 32'd1);
      check("rr_2", 32'(gq[2]), 32'd3);
      check("rr_3", 32'(gq[3]), 32'd0);
    end

    // Timeout on a ch1 read, then ch2 wins over ch1.
    req = 4'b0010; we = '0; len = '0;
    cyc(0);
    req = '0;
    rc = 0; ec = 0;
    for (int k = 0; k < 18; k++) begin
      if (read === 1'b1) rc++;
      if (error === 1'b1) ec++;
      cyc(0);
    end
    check("timeout_read_cycles", 32'(rc), 32'd16);
    check("timeout_error_cycles", 32'(ec), 32'd1);
    check("timeout_then_idle", 32'(idle), 32'd1);
    req = 4'b0110;
    cyc(1);
    check("timeout_skip_owner", 32'(gq[$]), 32'd2);
    req = '0;
    cyc(1); cyc(0);

    // Ack on the 16th cycle beats the watchdog.
    req = 4'b0001; len = '0; len[0 +: LEN_W] = 4'd1;
    cyc(0);
    req = '0;
    ec = 0;
    for (int k = 0; k < 15; k++) begin if (error === 1'b1) ec++; cyc(0); end
    cyc(1);
    check("tmo_boundary_beat", 32'(beat_cnt), 32'd1);
    for (int k = 0; k < 15; k++) begin if (error === 1'b1) ec++; cyc(0); end
    cyc(1);
    check("tmo_boundary_no_error", 32'(ec), 32'd0);
    check("tmo_boundary_idle", 32'(idle), 32'd1);
    cyc(0);

    // Inputs of the owner are ignored mid-burst.
    req = 4'b1000; we = 4'b1000; len = '0; len[3*LEN_W +: LEN_W] = 4'd2;
    cyc(1);
    req = '0; we = '0; len = '0;
    wc = 0;
    for (int k = 0; k < 5; k++) begin
      if (write === 1'b1) wc++;
      cyc(k % 2 == 0);
    end
    check("isolation_write_cycles", 32'(wc), 32'd5);
    check("isolation_idle_after", 32'(idle), 32'd1);

    // Random traffic with bursts of poor ack to provoke timeouts.
    for (int n = 0; n < 1200; n++) begin
      req = 4'($urandom); we = 4'($urandom); len = 16'($urandom & 32'h3333);
      if (n % 300 < 200) cyc(($urandom % 4) != 0);
      else cyc(($urandom % 10) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_arb.md
# fsm_arb

Parametrised successor to the single-requester read/write controller. It arbitrates CH requesters round-robin and runs multi-beat read or write bursts of per-request length. Each burst is tracked with a beat counter and guarded by an ack-timeout watchdog that forces a one-cycle ERROR state. It sits between the requesting channels and a single ack-driven target port.

## Interface
- CH, 4, number of request channels (≥2); IW = $clog2(CH)
- LEN_W, 4, burst length field width; burst = len+1 beats (1..2^LEN_W)
- TIMEOUT, 16, max consecutive non-ack cycles in READ/WRITE before ERROR (≥1)

- clk  input  1  clock, all state on posedge
- reset  input  1  asynchronous, active-high; all state cleared immediately on assertion
- req  input  CH  per-channel request, level
- we  input  CH  per-channel direction, 1=write 0=read, sampled with req
- len  input  CH*LEN_W  per-channel beat count minus one; channel i at [i*LEN_W +: LEN_W]
- ack  input  1  target accepts one beat this cycle
- idle  output  1  state==IDLE
- read  output  1  state==READ
- write  output  1  state==WRITE
- grant  output  CH  one-hot owning channel, nonzero only in READ/WRITE
- beat_cnt  output  LEN_W  beats acked so far in current burst
- done  output  1  last beat acked this cycle (combinational)
- error  output  1  state==ERROR

## Operation
- States: IDLE, READ, WRITE, ERROR; unused encodings go to IDLE.
- IDLE, any req bit set:
  - Pick the first set bit scanning from (ptr+1) mod CH upward, wrapping.
  - Latch channel index, we[ch] and len[ch].
  - Set ptr = ch.
  - Go to WRITE if latched we=1, else READ.
  - Clear beat_cnt and the timeout counter.
- IDLE with no req: stay; grant = 0.
- READ/WRITE:
  - grant = one-hot of the latched channel.
  - The req, we and len inputs of every channel are ignored until the state returns to IDLE. Dropping req mid-burst does not abort it.
- Each cycle with ack=1 in READ/WRITE:
  - If beat_cnt == latched len: done=1, next state IDLE, beat_cnt cleared.
  - Otherwise beat_cnt += 1.
  - Either way, the timeout counter is cleared.
- Each cycle with ack=0 in READ/WRITE: timeout counter += 1. When it reaches TIMEOUT, next state is ERROR.
- ERROR:
  - Lasts exactly one cycle, then IDLE.
  - error=1; idle/read/write = 0; grant = 0; ack ignored.
  - ptr stays at the failed channel, so the next grant goes to another requester if one exists.
- ack in IDLE or ERROR is ignored; done=0 in those states.
- Timeout counter width is $clog2(TIMEOUT+1). beat_cnt never exceeds latched len.

## Timing
- Reset values: state=IDLE (idle=1, read=0, write=0, error=0); grant=0; beat_cnt=0; done=0; ptr=CH-1, so channel 0 has first priority.
- Grant latency: req sampled in IDLE at edge N gives read/write and grant high from cycle N+1. No IDLE-to-burst bypass.
- Burst duration with ack held high: exactly len+1 cycles in READ/WRITE. done is high in the last of those cycles, and idle=1 the cycle after.
- Back-to-back bursts always pass through at least one IDLE cycle. A channel holding req continuously is re-arbitrated against the others each time.
- Timeout: TIMEOUT consecutive ack=0 cycles, then error=1 for one cycle, then idle=1.
- ack arriving on the cycle the count would reach TIMEOUT wins: the beat counts and no error is raised.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. No done or error is emitted. Arbitration restarts from channel 0.
- Outputs other than done are decoded from registered state only and are glitch-free with respect to inputs.

## Test plan
- Reset defaults: reset high mid-burst (READ, beat_cnt=2) → same cycle idle=1, grant=0, beat_cnt=0; after release, req=4'b1111 grants channel 0 first.
- Single write burst: ch2 req, we=1, len=3, ack held high → write=1 and grant=4'b0100 for 4 cycles; done on the 4th; idle next cycle.
- Round-robin fairness: req=4'b1011 held, len=0, ack=1 → grant order ch0, ch1, ch3, ch0, each separated by one idle cycle.
- Timeout: TIMEOUT=16, ch1 read, ack never asserted → 16 cycles read=1, then error=1 for 1 cycle, then idle=1; next grant skips to ch2 if ch1 and ch2 both request.
- Timeout boundary: ack=0 for 15 cycles, then ack=1 on the 16th → no error; beat_cnt increments; the counter restarts.
- Input isolation: during ch3 write with len=2, toggle req[3]=0, we[3]=0, len[3]=0 and pulse ack in 1-0-1-0-1 → burst completes after 3 acks, done on the 3rd ack, write stays high throughout.
